gpu_rect_fill: RTL and testbench
================================

Name: gpu_rect_fill

Overview:
Rectangle-fill rasterizer for the GPU pipeline. On a start command it latches two corner coordinates and an RGB colour. It then emits one pixel per clock, with coordinate and colour, covering every pixel of the inclusive rectangle in row-major order. Downstream framebuffer-write logic consumes (x_o, y_o, r_o, g_o, b_o) on every cycle busy_o is high.

Parameters:
WIDTH_BITS, 10, bit width of x coordinates (matches `WIDTH_BITS in gpu_definitions.vh)
HEIGHT_BITS, 9, bit width of y coordinates (matches `HEIGHT_BITS)
CHANNEL_BITS, 8, bit width of each colour channel (matches `CHANNEL_BITS)

Ports:
clk  in  1  system clock, rising-edge
n_rst  in  1  asynchronous active-high reset; despite the codebase name, 1 = reset asserted
x1_i  in  WIDTH_BITS  first corner x
y1_i  in  HEIGHT_BITS  first corner y
x2_i  in  WIDTH_BITS  second corner x
y2_i  in  HEIGHT_BITS  second corner y
r_i, g_i, b_i  in  CHANNEL_BITS each  fill colour
start_i  in  1  start command, level-sampled in IDLE
x_o  out  WIDTH_BITS  current pixel x
y_o  out  HEIGHT_BITS  current pixel y
r_o, g_o, b_o  out  CHANNEL_BITS each  current pixel colour
busy_o  out  1  high while x_o/y_o/colour is a valid pixel
done_o  out  1  one-cycle completion pulse

Behaviour:
- One clock domain, clk. Reset is asynchronous and active-high on n_rst; all flops clear immediately on assertion.
- Reset values: state=IDLE; x_o=0, y_o=0, r_o=g_o=b_o=0, busy_o=0, done_o=0.
- States:
  - IDLE: busy_o=0, done_o=0, outputs hold their last values. If start_i=1 at a rising edge:
    - latch xmin=min(x1_i,x2_i), xmax=max(x1_i,x2_i), ymin=min(y1_i,y2_i), ymax=max(y1_i,y2_i), and the colour;
    - load x_o=xmin, y_o=ymin, colour outputs = latched colour;
    - go to FILL.
  - FILL: busy_o=1 and the current pixel is valid. At each edge:
    - if x_o<xmax then x_o++;
    - else if y_o<ymax then x_o=xmin, y_o++;
    - else go to DONE.
  - DONE: busy_o=0, done_o=1 for exactly one cycle; next state is IDLE.
- Latency: first valid pixel appears in the cycle after the edge that samples start_i.
- Throughput: one pixel per clock.
- busy_o is high for exactly (xmax-xmin+1)*(ymax-ymin+1) consecutive cycles.
- Bounds are inclusive. A degenerate rectangle (x1=x2, y1=y2) yields exactly 1 pixel.
- Inputs and start_i are ignored during FILL and DONE; the latched values are used throughout.
- start_i held high: after DONE→IDLE, the next edge in IDLE starts a new fill with the current inputs (idle gap of 2 cycles between fills: DONE + IDLE).
- Counter comparisons are unsigned. xmax = 2^WIDTH_BITS-1 must not wrap: the row ends on equality before any increment.
- Reset mid-fill aborts immediately. Outputs return to reset values and no done_o pulse is produced.

Test Plan:
- Reset: assert n_rst=1 asynchronously mid-cycle → busy_o=0, done_o=0, x_o=y_o=0 immediately, without waiting for a clock edge.
- Full fill: corners (0,0),(200,150), colour (50,40,80), start pulse → busy_o high 30351 cycles.
  - Pixels (0,0),(1,0)…(200,0),(0,1)…(200,150) in order; r_o/g_o/b_o = 50/40/80 throughout.
  - done_o pulses once, the cycle after (200,150).
- Swapped corners: (5,7),(2,3) → same 4x5=20 pixels as (2,3),(5,7), starting at (2,3), ending at (5,7).
- Single pixel: (9,9),(9,9) → busy_o exactly 1 cycle with (9,9), then done_o pulse.
- Input change during fill: change x2_i, y2_i and r_i mid-fill → pixel sequence and colour unchanged.
- start_i held high continuously: a 2x2 rect repeats: 4 busy cycles, 1 done cycle, 1 idle cycle, repeat. Then reset mid-fill → abort with no done_o pulse.

Source files
------------

// File: rtl/gpu_rect_fill.sv
// Rectangle-fill rasterizer: latches two corners and a colour on start, then
// walks the inclusive rectangle in row-major order at one pixel per clock.
module gpu_rect_fill #(
    parameter int WIDTH_BITS   = 10,
    parameter int HEIGHT_BITS  = 9,
    parameter int CHANNEL_BITS = 8
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic [WIDTH_BITS-1:0]   x1_i,
    input  logic [HEIGHT_BITS-1:0]  y1_i,
    input  logic [WIDTH_BITS-1:0]   x2_i,
    input  logic [HEIGHT_BITS-1:0]  y2_i,
    input  logic [CHANNEL_BITS-1:0] r_i,
    input  logic [CHANNEL_BITS-1:0] g_i,
    input  logic [CHANNEL_BITS-1:0] b_i,
    input  logic                    start_i,
    output logic [WIDTH_BITS-1:0]   x_o,
    output logic [HEIGHT_BITS-1:0]  y_o,
    output logic [CHANNEL_BITS-1:0] r_o,
    output logic [CHANNEL_BITS-1:0] g_o,
    output logic [CHANNEL_BITS-1:0] b_o,
    output logic                    busy_o,
    output logic                    done_o
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_DONE
    } state_t;

    localparam logic [WIDTH_BITS-1:0]  X_ONE = 1;
    localparam logic [HEIGHT_BITS-1:0] Y_ONE = 1;

    state_t                  r_state;
    logic [WIDTH_BITS-1:0]   r_xmin;
    logic [WIDTH_BITS-1:0]   r_xmax;
    logic [HEIGHT_BITS-1:0]  r_ymax;

    logic [WIDTH_BITS-1:0]   w_xmin;
    logic [WIDTH_BITS-1:0]   w_xmax;
    logic [HEIGHT_BITS-1:0]  w_ymin;
    logic [HEIGHT_BITS-1:0]  w_ymax;

    // Corner ordering lets callers supply the rectangle in any orientation.
    assign w_xmin = (x1_i < x2_i) ? x1_i : x2_i;
    assign w_xmax = (x1_i < x2_i) ? x2_i : x1_i;
    assign w_ymin = (y1_i < y2_i) ? y1_i : y2_i;
    assign w_ymax = (y1_i < y2_i) ? y2_i : y1_i;

    // NOTE: all state and outputs live in one clocked block with non-blocking
    // assignments, so every output is a flop and reads see pre-edge values.
    always_ff @(posedge clk or posedge n_rst) begin
        if (n_rst) begin
            r_state <= ST_IDLE;
            r_xmin  <= '0;
            r_xmax  <= '0;
            r_ymax  <= '0;
            x_o     <= '0;
            y_o     <= '0;
            r_o     <= '0;
            g_o     <= '0;
            b_o     <= '0;
            busy_o  <= 1'b0;
            done_o  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    done_o <= 1'b0;
                    if (start_i) begin
                        r_xmin  <= w_xmin;
                        r_xmax  <= w_xmax;
                        r_ymax  <= w_ymax;
                        x_o     <= w_xmin;
                        y_o     <= w_ymin;
                        r_o     <= r_i;
                        g_o     <= g_i;
                        b_o     <= b_i;
                        busy_o  <= 1'b1;
                        r_state <= ST_FILL;
                    end
                end
                ST_FILL: begin
                    // Compare before incrementing so a row ending at the
                    // largest coordinate never wraps.
                    if (x_o < r_xmax) begin
                        x_o <= x_o + X_ONE;
                    end else if (y_o < r_ymax) begin
                        x_o <= r_xmin;
                        y_o <= y_o + Y_ONE;
                    end else begin
                        busy_o  <= 1'b0;
                        done_o  <= 1'b1;
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done_o  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    busy_o  <= 1'b0;
                    done_o  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gpu_rect_fill.sv
// Directed self-checking bench for gpu_rect_fill: walks each rectangle with a
// bench-side row-major model and checks every pixel, done pulse and idle gap.
module tb_gpu_rect_fill;

    logic       clk;
    logic       n_rst;
    logic [9:0] x1_i, x2_i;
    logic [8:0] y1_i, y2_i;
    logic [7:0] r_i, g_i, b_i;
    logic       start_i;
    logic [9:0] x_o;
    logic [8:0] y_o;
    logic [7:0] r_o, g_o, b_o;
    logic       busy_o;
    logic       done_o;

    int n_checks = 0;
    int n_fail   = 0;

    gpu_rect_fill #(
        .WIDTH_BITS  (10),
        .HEIGHT_BITS (9),
        .CHANNEL_BITS(8)
    ) dut (
        .clk    (clk),
        .n_rst  (n_rst),
        .x1_i   (x1_i),
        .y1_i   (y1_i),
        .x2_i   (x2_i),
        .y2_i   (y2_i),
        .r_i    (r_i),
        .g_i    (g_i),
        .b_i    (b_i),
        .start_i(start_i),
        .x_o    (x_o),
        .y_o    (y_o),
        .r_o    (r_o),
        .g_o    (g_o),
        .b_o    (b_o),
        .busy_o (busy_o),
        .done_o (done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present a command at a falling edge; the next rising edge samples it.
    // Returns at the falling edge where the first pixel should be visible.
    task automatic start_cmd(input int x1, input int y1, input int x2, input int y2,
                             input int r, input int g, input int b, input bit hold);
        @(negedge clk);
        x1_i    = 10'(x1);
        y1_i    = 9'(y1);
        x2_i    = 10'(x2);
        y2_i    = 9'(y2);
        r_i     = 8'(r);
        g_i     = 8'(g);
        b_i     = 8'(b);
        start_i = 1'b1;
        @(negedge clk);
        if (!hold) start_i = 1'b0;
    endtask

    // Checks every pixel of the rectangle from the current falling edge, then
    // the done pulse. At pixel index change_at the corner/colour inputs are
    // disturbed to confirm the latched values are used.
    task automatic check_fill(input string tag, input int xmin, input int xmax,
                              input int ymin, input int ymax,
                              input int r, input int g, input int b, input int change_at);
        int idx = 0;
        for (int y = ymin; y <= ymax; y++) begin
            for (int x = xmin; x <= xmax; x++) begin
                if (idx > 0) @(negedge clk);
                if (idx == change_at) begin
                    x2_i = 10'd900;
                    y2_i = 9'd400;
                    r_i  = 8'hEE;
                end
                check($sformatf("%s pixel %0d", tag, idx),
                      64'({busy_o, done_o, x_o, y_o, r_o, g_o, b_o}),
                      64'({1'b1, 1'b0, 10'(x), 9'(y), 8'(r), 8'(g), 8'(b)}));
                idx++;
            end
        end
        @(negedge clk);
        check({tag, " done pulse"}, 64'({busy_o, done_o}), 64'(2'b01));
    endtask

    task automatic check_idle(input string tag);
        @(negedge clk);
        check({tag, " idle"}, 64'({busy_o, done_o}), 64'(2'b00));
    endtask

    initial begin
        n_rst   = 1'b1;
        start_i = 1'b0;
        x1_i = '0; y1_i = '0; x2_i = '0; y2_i = '0;
        r_i  = '0; g_i  = '0; b_i  = '0;
        #12;
        check("reset state", 64'({busy_o, done_o, x_o, y_o, r_o, g_o, b_o}), 64'(0));
        @(negedge clk);
        n_rst = 1'b0;
        @(negedge clk);
        check("idle after reset", 64'({busy_o, done_o, x_o, y_o}), 64'(0));

        // Full fill of a 201 x 151 rectangle.
        start_cmd(0, 0, 200, 150, 50, 40, 80, 1'b0);
        check_fill("full", 0, 200, 0, 150, 50, 40, 80, -1);
        check_idle("full");
        @(negedge clk);
        check("full outputs hold in idle", 64'({busy_o, x_o, y_o, r_o}), 64'({1'b0, 10'd200, 9'd150, 8'd50}));

        // Swapped corners.
        start_cmd(5, 7, 2, 3, 1, 2, 3, 1'b0);
        check_fill("swapped", 2, 5, 3, 7, 1, 2, 3, -1);
        check_idle("swapped");

        // Degenerate single pixel.
        start_cmd(9, 9, 9, 9, 8'hAA, 8'h55, 8'h0F, 1'b0);
        check_fill("single", 9, 9, 9, 9, 8'hAA, 8'h55, 8'h0F, -1);
        check_idle("single");

        // Row ending at the largest x coordinate must not wrap.
        start_cmd(1023, 1, 1020, 0, 7, 7, 7, 1'b0);
        check_fill("xmax edge", 1020, 1023, 0, 1, 7, 7, 7, -1);
        check_idle("xmax edge");

        // Inputs disturbed mid-fill.
        start_cmd(10, 20, 13, 22, 100, 110, 120, 1'b0);
        check_fill("input change", 10, 13, 20, 22, 100, 110, 120, 5);
        check_idle("input change");

        // start_i held high: 4 busy, 1 done, 1 idle, repeat.
        start_cmd(3, 4, 4, 5, 9, 8, 7, 1'b1);
        check_fill("held rep0", 3, 4, 4, 5, 9, 8, 7, -1);
        check_idle("held rep0");
        @(negedge clk);
        check_fill("held rep1", 3, 4, 4, 5, 9, 8, 7, -1);
        check_idle("held rep1");
        @(negedge clk);
        check("held rep2 pixel 0", 64'({busy_o, x_o, y_o}), 64'({1'b1, 10'd3, 9'd4}));
        @(negedge clk);
        check("held rep2 pixel 1", 64'({busy_o, x_o, y_o}), 64'({1'b1, 10'd4, 9'd4}));

        // Asynchronous reset mid-cycle aborts the fill immediately.
        #2 n_rst = 1'b1;
        #1;
        check("async reset abort", 64'({busy_o, done_o, x_o, y_o, r_o, g_o, b_o}), 64'(0));
        start_i = 1'b0;
        @(negedge clk);
        n_rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check($sformatf("no done after abort %0d", i), 64'({busy_o, done_o}), 64'(2'b00));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
